// File: rtl/pe_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module   : pe_mac_seq
//  Brief    : Signed multiply-accumulate PE. Streams K_LEN weight/pixel pairs,
//             accumulates through a registered product stage, then rounds,
//             optionally applies ReLU, saturates and holds the result behind
//             a valid/ready output handshake.
//  Revision : 1.0  initial release
// ============================================================================
module pe_mac_seq #(
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int ACC_W    = 32,
    parameter int K_LEN    = 9,
    parameter int OUT_W    = 16,
    parameter int SHIFT    = 0,
    parameter int RELU     = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [WEIGHT_W-1:0] weight_i,
    input  logic signed [DATA_W-1:0]   pixel_i,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [OUT_W-1:0]    pixel_o,
    output logic                       sat_o,
    output logic                       ovf_o
);

    localparam int PROD_W = DATA_W + WEIGHT_W;
    localparam int CNT_W  = (K_LEN > 1) ? $clog2(K_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(K_LEN - 1);
    // Saturation bounds expressed in the ACC_W+1 post-processing width.
    localparam logic signed [ACC_W:0] OUT_MAX = {{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] OUT_MIN = {{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        ST_ACC = 2'd0,
        ST_FIN = 2'd1,
        ST_OUT = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [PROD_W-1:0]   prod_q, prod_d;
    logic                       prod_v_q, prod_v_d;
    logic                       ovf_q, ovf_d;
    logic                       out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0]    pixel_q, pixel_d;
    logic                       sat_q, sat_d;
    logic                       ovf_out_q, ovf_out_d;

    logic signed [PROD_W-1:0]   w_mult;
    logic signed [ACC_W-1:0]    w_addend;
    logic signed [ACC_W-1:0]    w_sum;
    logic                       w_add_ovf;
    logic signed [ACC_W:0]      w_sum_ext;
    logic signed [ACC_W:0]      w_shifted;
    logic signed [ACC_W:0]      w_relu;
    logic                       w_clip_hi;
    logic                       w_clip_lo;
    logic signed [OUT_W-1:0]    w_sat_val;

    assign w_mult    = weight_i * pixel_i;
    // Pending product (if any) folded into the running sum; shared by ACC and FIN.
    assign w_addend  = prod_v_q ? ACC_W'(prod_q) : '0;
    assign w_sum     = acc_q + w_addend;
    assign w_add_ovf = prod_v_q && (acc_q[ACC_W-1] == w_addend[ACC_W-1])
                                && (w_sum[ACC_W-1] != acc_q[ACC_W-1]);
    assign w_sum_ext = (ACC_W + 1)'(w_sum);

    // Round-half-up right shift; the extra bit keeps the rounding add from wrapping.
    generate
        if (SHIFT > 0) begin : g_shift
            localparam logic signed [ACC_W:0] RND = (ACC_W + 1)'(1) <<< (SHIFT - 1);
            logic signed [ACC_W:0] w_rounded;
            assign w_rounded = w_sum_ext + RND;
            assign w_shifted = w_rounded >>> SHIFT;
        end else begin : g_noshift
            assign w_shifted = w_sum_ext;
        end
    endgenerate

    assign w_relu    = ((RELU != 0) && w_shifted[ACC_W]) ? '0 : w_shifted;
    assign w_clip_hi = (w_relu > OUT_MAX);
    assign w_clip_lo = (w_relu < OUT_MIN);
    assign w_sat_val = w_clip_hi ? OUT_MAX[OUT_W-1:0] :
                       w_clip_lo ? OUT_MIN[OUT_W-1:0] : w_relu[OUT_W-1:0];

    assign in_ready  = (state_q == ST_ACC);
    assign out_valid = out_valid_q;
    assign pixel_o   = pixel_q;
    assign sat_o     = sat_q;
    assign ovf_o     = ovf_out_q;

    // Next-state and datapath update; flush overrides everything but reset.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        prod_v_d    = prod_v_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        pixel_d     = pixel_q;
        sat_d       = sat_q;
        ovf_out_d   = ovf_out_q;
        if (flush) begin
            state_d     = ST_ACC;
            cnt_d       = '0;
            acc_d       = '0;
            prod_v_d    = 1'b0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_ACC: begin
                    acc_d    = w_sum;
                    ovf_d    = ovf_q | w_add_ovf;
                    prod_v_d = in_valid;
                    if (in_valid) begin
                        prod_d = w_mult;
                        if (cnt_q == CNT_LAST) begin
                            cnt_d   = '0;
                            state_d = ST_FIN;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_FIN: begin
                    pixel_d     = w_sat_val;
                    sat_d       = w_clip_hi | w_clip_lo;
                    ovf_out_d   = ovf_q | w_add_ovf;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    prod_v_d    = 1'b0;
                    ovf_d       = 1'b0;
                    state_d     = ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = ST_ACC;
                    end
                end
                default: begin
                    state_d = ST_ACC;
                end
            endcase
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_ACC;
            cnt_q       <= '0;
            acc_q       <= '0;
            prod_q      <= '0;
            prod_v_q    <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            pixel_q     <= '0;
            sat_q       <= 1'b0;
            ovf_out_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            prod_v_q    <= prod_v_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            pixel_q     <= pixel_d;
            sat_q       <= sat_d;
            ovf_out_q   <= ovf_out_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_mac_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pe_mac_seq
//  Brief    : Self-checking bench for pe_mac_seq. Four instances with
//             different post-processing configurations share one stimulus
//             stream and are compared against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pe_mac_seq;

    localparam int NDUT = 4;
    // Per-instance configuration: default, ReLU, SHIFT=2, narrow accumulator.
    localparam int CFG_SHIFT [NDUT] = '{0, 0, 2, 0};
    localparam int CFG_RELU  [NDUT] = '{0, 1, 0, 0};
    localparam int CFG_ACCW  [NDUT] = '{32, 32, 32, 17};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic signed [7:0] weight = '0;
    logic signed [7:0] pixel = '0;

    logic               rdy   [NDUT];
    logic               ov    [NDUT];
    logic signed [15:0] pix   [NDUT];
    logic               sat   [NDUT];
    logic               ovf   [NDUT];

    int n_assert = 0;
    int n_fail   = 0;
    longint prods[$];

    always #5 clk = ~clk;

    pe_mac_seq #(.SHIFT(0), .RELU(0), .ACC_W(32)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
        .weight_i(weight), .pixel_i(pixel), .out_valid(ov[0]), .out_ready(out_ready),
        .pixel_o(pix[0]), .sat_o(sat[0]), .ovf_o(ovf[0]));
    pe_mac_seq #(.SHIFT(0), .RELU(1), .ACC_W(32)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
        .weight_i(weight), .pixel_i(pixel), .out_valid(ov[1]), .out_ready(out_ready),
        .pixel_o(pix[1]), .sat_o(sat[1]), .ovf_o(ovf[1]));
    pe_mac_seq #(.SHIFT(2), .RELU(0), .ACC_W(32)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[2]),
        .weight_i(weight), .pixel_i(pixel), .out_valid(ov[2]), .out_ready(out_ready),
        .pixel_o(pix[2]), .sat_o(sat[2]), .ovf_o(ovf[2]));
    pe_mac_seq #(.SHIFT(0), .RELU(0), .ACC_W(17)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy[3]),
        .weight_i(weight), .pixel_i(pixel), .out_valid(ov[3]), .out_ready(out_ready),
        .pixel_o(pix[3]), .sat_o(sat[3]), .ovf_o(ovf[3]));

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: true integer dot product, wrapped to accw bits step by step,
    // then rounded shift, ReLU and clamp to 16 bits.
    task automatic model(input int shift, input int relu, input int accw,
                         output longint pix_e, output longint sat_e, output longint ovf_e);
        longint hi, lo, span, acc, t, r;
        hi   = (64'sd1 <<< (accw - 1)) - 1;
        lo   = -(64'sd1 <<< (accw - 1));
        span = 64'sd1 <<< accw;
        acc  = 0;
        ovf_e = 0;
        foreach (prods[i]) begin
            t = acc + prods[i];
            if (t > hi || t < lo) ovf_e = 1;
            if (t > hi) t -= span;
            if (t < lo) t += span;
            acc = t;
        end
        r = acc;
        if (shift > 0) r = (r + (64'sd1 <<< (shift - 1))) >>> shift;
        if (relu != 0 && r < 0) r = 0;
        sat_e = 0;
        if (r > 32767)  begin r = 32767;  sat_e = 1; end
        if (r < -32768) begin r = -32768; sat_e = 1; end
        pix_e = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic signed [7:0] w, input logic signed [7:0] p);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        weight = w;
        pixel = p;
        while (!rdy[0] && guard < 64) begin
            tick();
            guard++;
        end
        if (!rdy[0]) chk("send_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
        prods.push_back(longint'(w) * longint'(p));
    endtask

    task automatic wait_out(input string tag);
        int guard;
        guard = 0;
        while (!ov[0] && guard < 64) begin
            tick();
            guard++;
        end
        if (!ov[0]) chk({tag, "_out_timeout"}, 0, 1);
    endtask

    // Compare every instance with the model, then release the result.
    task automatic collect(input string tag);
        longint pe, se, oe;
        wait_out(tag);
        for (int d = 0; d < NDUT; d++) begin
            model(CFG_SHIFT[d], CFG_RELU[d], CFG_ACCW[d], pe, se, oe);
            chk($sformatf("%s_d%0d_valid", tag, d), longint'(ov[d]), 1);
            chk($sformatf("%s_d%0d_pixel", tag, d), longint'(pix[d]), pe);
            chk($sformatf("%s_d%0d_sat", tag, d), longint'(sat[d]), se);
            chk($sformatf("%s_d%0d_ovf", tag, d), longint'(ovf[d]), oe);
        end
        prods.delete();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, longint'(ov[0]), 0);
        chk({tag, "_inready_back"}, longint'(rdy[0]), 1);
    endtask

    initial begin
        logic signed [15:0] held;
        // ---------------- reset ----------------
        tick();
        tick();
        chk("rst_out_valid", longint'(ov[0]), 0);
        chk("rst_pixel", longint'(pix[0]), 0);
        chk("rst_sat", longint'(sat[0]), 0);
        chk("rst_ovf", longint'(ovf[0]), 0);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", longint'(rdy[0]), 1);

        // ---- weights 1, pixels 1..9: latency, backpressure, value ----
        for (int i = 1; i <= 9; i++) send(8'sd1, 8'(i));
        chk("fin_in_ready", longint'(rdy[0]), 0);
        chk("fin_out_valid", longint'(ov[0]), 0);
        tick();
        chk("lat_out_valid", longint'(ov[0]), 1);
        chk("sum45_pixel", longint'(pix[0]), 45);
        chk("sum45_shift2", longint'(pix[2]), 11);
        held = pix[0];
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("bp_pixel_stable", longint'(pix[0]), longint'(held));
            chk("bp_in_ready", longint'(rdy[0]), 0);
            chk("bp_valid_held", longint'(ov[0]), 1);
        end
        collect("sum45");

        // ---- saturation both directions ----
        for (int i = 0; i < 9; i++) send(8'sd127, 8'sd127);
        wait_out("satpos");
        chk("satpos_pixel", longint'(pix[0]), 32767);
        collect("satpos");
        for (int i = 0; i < 9; i++) send(-8'sd128, 8'sd127);
        wait_out("satneg");
        chk("satneg_pixel", longint'(pix[0]), -32768);
        collect("satneg");

        // ---- negative sum (ReLU), 46 for rounding ----
        for (int i = 1; i <= 9; i++) send(-8'sd1, 8'(i));
        collect("neg45");
        for (int i = 1; i <= 9; i++) send(8'sd1, (i == 9) ? 8'sd10 : 8'(i));
        wait_out("sum46");
        chk("sum46_shift2", longint'(pix[2]), 12);
        collect("sum46");

        // ---- bubbles: in_valid every other cycle ----
        for (int i = 1; i <= 9; i++) begin
            send(8'sd1, 8'(i));
            tick();
        end
        collect("bubble");

        // ---- flush mid-accumulation; input in flush cycle is dropped ----
        for (int i = 0; i < 4; i++) send(8'sd3, 8'sd5);
        flush = 1'b1;
        in_valid = 1'b1;
        weight = 8'sd50;
        pixel = 8'sd50;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        prods.delete();
        for (int i = 0; i < 9; i++) send(8'sd1, 8'sd1);
        wait_out("flush9");
        chk("flush9_pixel", longint'(pix[0]), 9);
        collect("flush9");

        // ---- flush while result held: never re-emitted ----
        for (int i = 0; i < 9; i++) send(8'sd2, 8'sd2);
        wait_out("flushout");
        flush = 1'b1;
        tick();
        flush = 1'b0;
        prods.delete();
        chk("flushout_valid", longint'(ov[0]), 0);
        for (int c = 0; c < 4; c++) tick();
        chk("flushout_no_reemit", longint'(ov[0]), 0);
        chk("flushout_in_ready", longint'(rdy[0]), 1);

        // ---- reset pulse mid-stream ----
        for (int i = 0; i < 3; i++) send(8'sd7, -8'sd3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        prods.delete();
        chk("midrst_valid", longint'(ov[0]), 0);
        chk("midrst_pixel", longint'(pix[0]), 0);
        chk("midrst_sat", longint'(sat[0]), 0);
        chk("midrst_ovf", longint'(ovf[0]), 0);
        for (int i = 1; i <= 9; i++) send(8'(i), 8'sd2);
        collect("postrst");

        // ---- randomized dot products with random idle gaps ----
        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < 9; i++) begin
                send(8'($urandom), 8'($urandom));
                if ($urandom_range(0, 3) == 0) tick();
            end
            collect($sformatf("rand%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
